// File: rtl/phase_ref_gen_if.sv
// Bus bundle for phase_ref_gen: update strobe, modulation controls in,
// per-phase compare words and status flags out.
interface phase_ref_gen_if #(
  parameter int PhaseCount = 3,
  parameter int BIT_WIDTH  = 16,
  parameter int AccWidth   = 32
);
  logic                 Enable;
  logic                 SyncPulse;
  logic [AccWidth-1:0]  FreqWord;
  logic [BIT_WIDTH-1:0] ModIndex;
  logic [BIT_WIDTH-1:0] PWMMaxCount;
  logic [BIT_WIDTH-1:0] Compare [PhaseCount];
  logic                 CompareValid;
  logic                 Busy;
  logic                 Overrun;

  modport master (
    output Enable, SyncPulse, FreqWord, ModIndex, PWMMaxCount,
    input  Compare, CompareValid, Busy, Overrun
  );

  modport slave (
    input  Enable, SyncPulse, FreqWord, ModIndex, PWMMaxCount,
    output Compare, CompareValid, Busy, Overrun
  );
endinterface

// File: rtl/phase_ref_gen.sv
// Three-phase sine reference generator: one shared quarter-wave LUT and a
// 4-stage multiply pipeline feed shadow registers that commit all phases at once.
module phase_ref_gen #(
  parameter int PhaseCount   = 3,
  parameter int BIT_WIDTH    = 16,
  parameter int AccWidth     = 32,
  parameter int LutAddrWidth = 8
) (
  input  logic          MClk,
  input  logic          Rst,
  phase_ref_gen_if.slave bus
);
  localparam int W        = BIT_WIDTH;
  localparam int LutDepth = 2 ** LutAddrWidth;
  localparam int CntWidth = $clog2(PhaseCount + 3);
  localparam int KW       = (PhaseCount > 1) ? $clog2(PhaseCount) : 1;

  typedef enum logic [1:0] {IDLE, CALC, COMMIT} state_e;

  // Integer Taylor series (Q30) so the ROM contents fold to constants anywhere.
  function automatic logic [BIT_WIDTH-1:0] lut_entry(input int j);
    longint x, x2, term, acc, amp;
    x    = (64'sd3373259426 * longint'(2 * j + 1)) >>> (LutAddrWidth + 2);
    x2   = (x * x) >>> 30;
    term = x;
    acc  = x;
    for (int n = 1; n <= 6; n++) begin
      term = -(((term * x2) >>> 30) / longint'(4 * n * n + 2 * n));
      acc  = acc + term;
    end
    amp = (acc * longint'((1 << (BIT_WIDTH - 1)) - 1) + (64'sd1 <<< 29)) >>> 30;
    return BIT_WIDTH'(amp);
  endfunction

  function automatic logic [AccWidth-1:0] phase_offset(input int k);
    logic [63:0] num;
    num = 64'(k) << AccWidth;
    return AccWidth'(num / 64'(PhaseCount));
  endfunction

  logic [W-1:0]        lut    [LutDepth];
  logic [AccWidth-1:0] offset [PhaseCount];

  for (genvar j = 0; j < LutDepth; j++) begin : g_lut
    localparam logic [W-1:0] Entry = lut_entry(j);
    assign lut[j] = Entry;
  end

  for (genvar k = 0; k < PhaseCount; k++) begin : g_off
    localparam logic [AccWidth-1:0] Off = phase_offset(k);
    assign offset[k] = Off;
  end

  state_e                 state_q, state_d;
  logic [AccWidth-1:0]    acc_q, acc_d;
  logic [W-1:0]           mod_q, mod_d, max_q, max_d, half_q, half_d;
  logic [CntWidth-1:0]    cnt_q, cnt_d;
  logic                   busy_q, busy_d, overrun_q, overrun_d, valid_q, valid_d;
  logic [W-1:0]           compare_q [PhaseCount];
  logic [W-1:0]           compare_d [PhaseCount];
  logic [W-1:0]           shadow_q  [PhaseCount];
  logic [W-1:0]           shadow_d  [PhaseCount];
  logic                   s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d, s3_vld_q, s3_vld_d;
  logic [KW-1:0]          s1_k_q, s1_k_d, s2_k_q, s2_k_d, s3_k_q, s3_k_d;
  logic [W-1:0]           s1_mag_q, s1_mag_d;
  logic                   s1_neg_q, s1_neg_d;
  logic signed [W:0]      s2_m_q, s2_m_d;
  logic signed [W+1:0]    s3_d_q, s3_d_d;

  logic [KW-1:0]             issue_k;
  logic [LutAddrWidth+1:0]   lut_top;
  logic [LutAddrWidth-1:0]   lut_addr;
  logic signed [W-1:0]       s_val;
  logic signed [2*W:0]       prod2;
  logic signed [2*W+1:0]     prod3;
  logic signed [W+1:0]       c_sum;

  // NOTE: every signal gets a default at the top so no path leaves a latch.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mod_d     = mod_q;
    max_d     = max_q;
    half_d    = half_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q | (bus.SyncPulse & (state_q != IDLE));
    compare_d = compare_q;
    shadow_d  = shadow_q;
    s1_vld_d  = 1'b0;
    s1_k_d    = s1_k_q;
    s1_mag_d  = s1_mag_q;
    s1_neg_d  = s1_neg_q;

    issue_k  = KW'(cnt_q);
    lut_top  = (LutAddrWidth + 2)'((acc_q + offset[issue_k]) >> (AccWidth - LutAddrWidth - 2));
    lut_addr = lut_top[LutAddrWidth-1:0] ^ {LutAddrWidth{lut_top[LutAddrWidth]}};

    unique case (state_q)
      IDLE: if (bus.SyncPulse && bus.Enable) begin
        acc_d   = acc_q + bus.FreqWord;
        mod_d   = bus.ModIndex;
        max_d   = bus.PWMMaxCount;
        half_d  = bus.PWMMaxCount >> 1;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q < CntWidth'(PhaseCount)) begin
          s1_vld_d = 1'b1;
          s1_k_d   = issue_k;
          s1_mag_d = lut[lut_addr];
          s1_neg_d = lut_top[LutAddrWidth+1];
        end
        if (cnt_q == CntWidth'(PhaseCount + 2)) state_d = COMMIT;
      end
      COMMIT: begin
        compare_d = shadow_q;
        valid_d   = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    s_val    = s1_neg_q ? -s1_mag_q : s1_mag_q;
    prod2    = (2*W+1)'(s_val) * (2*W+1)'($signed({1'b0, mod_q}));
    s2_vld_d = s1_vld_q;
    s2_k_d   = s1_k_q;
    s2_m_d   = (W+1)'(prod2 >>> W);

    prod3    = (2*W+2)'(s2_m_q) * (2*W+2)'($signed({1'b0, half_q}));
    s3_vld_d = s2_vld_q;
    s3_k_d   = s2_k_q;
    s3_d_d   = (W+2)'(prod3 >>> (W - 1));

    c_sum = (W+2)'($signed({1'b0, half_q})) + s3_d_q;
    if (s3_vld_q) begin
      if (c_sum < 0)                                       shadow_d[s3_k_q] = '0;
      else if (c_sum > (W+2)'($signed({1'b0, max_q})))     shadow_d[s3_k_q] = max_q;
      else                                                 shadow_d[s3_k_q] = c_sum[W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge MClk) begin
    if (Rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mod_q     <= '0;
      max_q     <= '0;
      half_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      compare_q <= '{default: '0};
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s3_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mod_q     <= mod_d;
      max_q     <= max_d;
      half_q    <= half_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      compare_q <= compare_d;
      s1_vld_q  <= s1_vld_d;
      s2_vld_q  <= s2_vld_d;
      s3_vld_q  <= s3_vld_d;
    end
  end

  // NOTE: shadow and pipeline data are not reset; the valid bits guard them
  // and every phase is rewritten before any commit.
  always_ff @(posedge MClk) begin
    shadow_q <= shadow_d;
    s1_k_q   <= s1_k_d;
    s1_mag_q <= s1_mag_d;
    s1_neg_q <= s1_neg_d;
    s2_k_q   <= s2_k_d;
    s2_m_q   <= s2_m_d;
    s3_k_q   <= s3_k_d;
    s3_d_q   <= s3_d_d;
  end

  for (genvar p = 0; p < PhaseCount; p++) begin : g_out
    assign bus.Compare[p] = compare_q[p];
  end
  assign bus.CompareValid = valid_q;
  assign bus.Busy         = busy_q;
  assign bus.Overrun      = overrun_q;
endmodule

// File: tb/tb_phase_ref_gen.sv
// Directed bench for phase_ref_gen with hand-computed compare values.
module tb_phase_ref_gen;
  localparam int PC = 3;
  localparam int W  = 16;
  localparam int AW = 32;
  localparam int LA = 8;

  logic MClk = 1'b0;
  logic Rst  = 1'b1;
  always #5 MClk = ~MClk;

  phase_ref_gen_if #(.PhaseCount(PC), .BIT_WIDTH(W), .AccWidth(AW)) bus ();

  phase_ref_gen #(.PhaseCount(PC), .BIT_WIDTH(W), .AccWidth(AW), .LutAddrWidth(LA)) dut (
    .MClk (MClk),
    .Rst  (Rst),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;

  int         lat;
  logic       busy_seen;
  logic [W-1:0] prev_c [PC];
  int         vcount;
  logic [W-1:0] first_c0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  // Strobe SyncPulse for one edge and wait (bounded) for CompareValid.
  task automatic fire_and_wait();
    lat = -1;
    @(negedge MClk); bus.SyncPulse = 1'b1;
    @(posedge MClk); #1; bus.SyncPulse = 1'b0;
    busy_seen = bus.Busy;
    for (int n = 1; n <= 20; n++) begin
      for (int p = 0; p < PC; p++) prev_c[p] = bus.Compare[p];
      @(posedge MClk); #1;
      if (bus.CompareValid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_valid(input int cycles);
    vcount = 0;
    first_c0 = '0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge MClk); #1;
      if (bus.CompareValid) begin
        if (vcount == 0) first_c0 = bus.Compare[0];
        vcount++;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge MClk); Rst = 1'b1;
    repeat (2) @(posedge MClk);
    #1;
  endtask

  int exp_sweep [4] = '{999, 498, 0, 501};

  initial begin
    bus.Enable      = 1'b1;
    bus.SyncPulse   = 1'b0;
    bus.FreqWord    = '0;
    bus.ModIndex    = '0;
    bus.PWMMaxCount = 16'd1000;

    repeat (2) @(posedge MClk);
    #1;
    for (int p = 0; p < PC; p++) check($sformatf("rst_cmp%0d", p), bus.Compare[p], 0);
    check("rst_valid",   bus.CompareValid, 0);
    check("rst_busy",    bus.Busy, 0);
    check("rst_overrun", bus.Overrun, 0);
    @(negedge MClk); Rst = 1'b0;

    // ModIndex 0: every phase sits at half the carrier
    fire_and_wait();
    check("m0_latency", lat, 7);
    check("m0_busy_on", busy_seen, 1);
    check("m0_busy_off", bus.Busy, 0);
    for (int p = 0; p < PC; p++) check($sformatf("m0_cmp%0d", p), bus.Compare[p], 500);
    @(posedge MClk); #1;
    check("m0_valid_1cyc", bus.CompareValid, 0);

    // Full index at angle 0: 120-degree spread, committed on one edge
    bus.ModIndex = 16'hFFFF;
    fire_and_wait();
    check("full_latency", lat, 7);
    check("full_cmp0", bus.Compare[0], 501);
    check("full_cmp1", bus.Compare[1], 932);
    check("full_cmp2", bus.Compare[2], 67);
    for (int p = 0; p < PC; p++) check($sformatf("full_prev%0d", p), prev_c[p], 500);

    // Quarter-turn steps, accumulator wraps back to 0 on the fourth
    bus.FreqWord = 32'h4000_0000;
    for (int i = 0; i < 4; i++) begin
      fire_and_wait();
      check($sformatf("sweep%0d_lat", i), lat, 7);
      check($sformatf("sweep%0d_cmp0", i), bus.Compare[0], exp_sweep[i]);
      repeat (2) @(posedge MClk);
    end

    // Second strobe 3 cycles into a computation
    do_reset();
    @(negedge MClk); Rst = 1'b0;
    @(negedge MClk); bus.SyncPulse = 1'b1;
    @(posedge MClk); #1; bus.SyncPulse = 1'b0;
    repeat (2) @(posedge MClk);
    @(negedge MClk); bus.SyncPulse = 1'b1;
    @(posedge MClk); #1; bus.SyncPulse = 1'b0;
    check("ovr_set", bus.Overrun, 1);
    count_valid(15);
    check("ovr_valid_cnt", vcount, 1);
    check("ovr_first_cmp0", first_c0, 999);
    fire_and_wait();
    check("ovr_next_cmp0", bus.Compare[0], 498);
    check("ovr_sticky", bus.Overrun, 1);
    do_reset();
    check("ovr_cleared", bus.Overrun, 0);
    check("ovr_rst_cmp0", bus.Compare[0], 0);
    @(negedge MClk); Rst = 1'b0;

    // Enable low: strobe ignored, accumulator untouched
    bus.Enable = 1'b0;
    @(negedge MClk); bus.SyncPulse = 1'b1;
    @(posedge MClk); #1; bus.SyncPulse = 1'b0;
    check("dis_busy", bus.Busy, 0);
    count_valid(10);
    check("dis_valid_cnt", vcount, 0);
    check("dis_cmp0", bus.Compare[0], 0);
    bus.Enable = 1'b1;
    fire_and_wait();
    check("en_cmp0", bus.Compare[0], 999);

    // Reset mid-CALC aborts the computation
    @(negedge MClk); bus.SyncPulse = 1'b1;
    @(posedge MClk); #1; bus.SyncPulse = 1'b0;
    repeat (2) @(posedge MClk);
    @(negedge MClk); Rst = 1'b1;
    @(posedge MClk); #1;
    check("abort_busy", bus.Busy, 0);
    check("abort_cmp0", bus.Compare[0], 0);
    check("abort_valid", bus.CompareValid, 0);
    @(negedge MClk); Rst = 1'b0;
    count_valid(10);
    check("abort_valid_cnt", vcount, 0);

    // Reset and strobe on the same edge: reset wins, accumulator stays 0
    @(negedge MClk); Rst = 1'b1; bus.SyncPulse = 1'b1;
    @(posedge MClk); #1; bus.SyncPulse = 1'b0;
    @(negedge MClk); Rst = 1'b0;
    check("rstsync_busy", bus.Busy, 0);
    count_valid(10);
    check("rstsync_valid_cnt", vcount, 0);
    fire_and_wait();
    check("rstsync_cmp0", bus.Compare[0], 999);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
